func_sweep_ctrl: RTL
====================

Name: func_sweep_ctrl

Overview:
- Sequencer that drives an external N_IN-input combinational function block through every input vector in ascending order.
- Holds each vector for SETTLE clocks, samples the block's output and assembles the full truth table as a minterm mask.
- Counts the ones and compares the mask against an expected mask.
- Sits between a bench or host controller (start/done handshake) and the combinational block under test. Vector bit N_IN-1 drives the block's first input (A), bit 0 the last (D).

Parameters:
- N_IN, 4: number of function inputs; legal 1..6; mask width is 2**N_IN.
- SETTLE, 2: clocks each vector is held before and including its sample cycle; legal >=1 (0 is treated as 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- expected  input  2**N_IN  expected truth-table mask; bit i = expected f for vector i; latched at accepted start.
- f  input  1  output of the function block under test.
- vec  output  N_IN  input vector driven to the function block.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse; results valid.
- mask  output  2**N_IN  captured truth table; bit i = f sampled for vector i.
- ones_cnt  output  N_IN+1  number of ones in mask.
- match  output  1  mask == latched expected.

Behaviour:
- All outputs registered. Reset values: vec=0, busy=0, done=0, mask=0, ones_cnt=0, match=0; state=IDLE; internal counters=0.
- Reset asserted mid-sweep forces the reset values on the next edge. The partial mask is discarded and no done is issued.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 -> DRIVE, vec<=0, cnt<=SETTLE-1, busy<=1, exp_q<=expected, mask<=0, ones_cnt<=0, match<=0.
  - start=0 -> stay; results of the previous sweep are held.
- DRIVE with cnt!=0: cnt<=cnt-1; vec held.
- DRIVE with cnt==0 (sample cycle):
  - mask[vec]<=f; ones_cnt<=ones_cnt+f.
  - If vec==2**N_IN-1 -> DONE; otherwise vec<=vec+1 and cnt<=SETTLE-1.
- vec never wraps during a sweep. It keeps the last vector (all ones) until the next start.
- DONE (one cycle):
  - done=1, busy=1.
  - match registered on entry to DONE, computed from the final mask including the last sample.
  - Next state IDLE, with busy<=0.
- Latency: the start-sampling edge is edge 0. The sample for vector i occurs on edge (i+1)*SETTLE. done is high during the cycle after edge 2**N_IN*SETTLE.
- start while busy (DRIVE or DONE) is ignored, not queued.
- start held high continuously starts a new sweep on the edge after DONE, i.e. from IDLE.
- expected may change during a sweep without effect; only the latched exp_q is used.
- ones_cnt width N_IN+1 holds the maximum value 2**N_IN without overflow.

Optional Feature:
- Macro: SWEEP_FIRST_MISS_EN.
- Defined: adds output miss_valid (1 bit) and output miss_idx (N_IN bits), both reset to 0 and cleared on accepted start.
  - On the first sample cycle where f != exp_q[vec]: miss_valid<=1, miss_idx<=vec. Later mismatches do not update them.
  - Values are valid at done. miss_valid==~match at done.
- Undefined: neither port exists and no related logic is built. All other behaviour is identical.

Test Plan:
- Reference function F=(A^B)&(C|~D), N_IN=4, SETTLE=2, expected=16'h0DD0, start pulse -> vec steps 0..15, each held 2 cycles; done pulse during the cycle after edge 32; mask=16'h0DD0, ones_cnt=6, match=1, busy low the cycle after done.
- Same function, expected=16'h0DD1 -> mask=16'h0DD0, match=0. With SWEEP_FIRST_MISS_EN: miss_valid=1, miss_idx=0.
- f tied to 1, SETTLE=1 -> done during the cycle after edge 16; mask=16'hFFFF, ones_cnt=16 (5'b10000), match=1 when expected=16'hFFFF.
- Pulse start again on edges 5 and 20 of an active sweep -> both ignored; one done only; then a start in IDLE runs a fresh sweep with mask cleared.
- Assert rst at edge 10 of a sweep -> next cycle all outputs at reset values, state IDLE, no done; a subsequent start runs a complete, correct sweep.
- Hold start high continuously, f tied to 0 -> back-to-back sweeps, one done every 2**N_IN*SETTLE+2 clocks; mask=0, ones_cnt=0 each time.

Source files
------------

// File: rtl/func_sweep_ctrl.sv
// Truth-table sweeper: walks an external N_IN-input combinational block through every
// vector, captures f into a minterm mask, counts ones and compares. Optional: SWEEP_FIRST_MISS_EN.
module func_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  expected,
  input  logic                  f,
  output logic [N_IN-1:0]       vec,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<N_IN)-1:0]  mask,
  output logic [N_IN:0]         ones_cnt,
  output logic                  match
`ifdef SWEEP_FIRST_MISS_EN
  ,
  output logic                  miss_valid,
  output logic [N_IN-1:0]       miss_idx
`endif
);

  // Handshake: start is a level sampled only in IDLE (ignored while busy, never queued);
  // done is a one-cycle pulse, and mask/ones_cnt/match stay stable from done until the next accepted start.

  localparam int M     = 1 << N_IN;
  localparam int S_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;
  localparam logic [CW-1:0]   CNT_RELOAD = CW'(S_EFF - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [M-1:0]    exp_q, exp_q_n;
  logic [N_IN-1:0] vec_n;
  logic            busy_n, done_n, match_n;
  logic [M-1:0]    mask_n;
  logic [N_IN:0]   ones_n;
`ifdef SWEEP_FIRST_MISS_EN
  logic            miss_valid_n;
  logic [N_IN-1:0] miss_idx_n;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exp_q_n = exp_q;
    vec_n   = vec;
    busy_n  = busy;
    done_n  = 1'b0;
    mask_n  = mask;
    ones_n  = ones_cnt;
    match_n = match;
`ifdef SWEEP_FIRST_MISS_EN
    miss_valid_n = miss_valid;
    miss_idx_n   = miss_idx;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = DRIVE;
          vec_n   = '0;
          cnt_n   = CNT_RELOAD;
          busy_n  = 1'b1;
          exp_q_n = expected;
          mask_n  = '0;
          ones_n  = '0;
          match_n = 1'b0;
`ifdef SWEEP_FIRST_MISS_EN
          miss_valid_n = 1'b0;
          miss_idx_n   = '0;
`endif
        end
      end
      DRIVE: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          mask_n[vec] = f;
          ones_n      = ones_cnt + {{N_IN{1'b0}}, f};
`ifdef SWEEP_FIRST_MISS_EN
          // Only the first disagreement is recorded.
          if (!miss_valid && (f != exp_q[vec])) begin
            miss_valid_n = 1'b1;
            miss_idx_n   = vec;
          end
`endif
          if (vec == VEC_LAST) begin
            // vec parks at all-ones; match uses the mask including this last sample.
            state_n = DONE;
            done_n  = 1'b1;
            match_n = (mask_n == exp_q);
          end else begin
            vec_n = vec + N_IN'(1);
            cnt_n = CNT_RELOAD;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      exp_q    <= '0;
      vec      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mask     <= '0;
      ones_cnt <= '0;
      match    <= 1'b0;
`ifdef SWEEP_FIRST_MISS_EN
      miss_valid <= 1'b0;
      miss_idx   <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      exp_q    <= exp_q_n;
      vec      <= vec_n;
      busy     <= busy_n;
      done     <= done_n;
      mask     <= mask_n;
      ones_cnt <= ones_n;
      match    <= match_n;
`ifdef SWEEP_FIRST_MISS_EN
      miss_valid <= miss_valid_n;
      miss_idx   <= miss_idx_n;
`endif
    end
  end

endmodule
